// File: rtl/vortex_axil_ctrl_pkg.sv
// Shared definitions for the Vortex AXI4-Lite host control block:
// register offsets, CTRL bit positions, response codes and FSM states.
`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

package vortex_axil_ctrl_pkg;

    // Word offsets, taken from address bits [4:2]
    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_DCR_ADDR  = 3'd2;
    localparam logic [2:0] REG_DCR_DATA  = 3'd3;
    localparam logic [2:0] REG_DEV_MASK  = 3'd4;
    localparam logic [2:0] REG_CYCLES_LO = 3'd5;
    localparam logic [2:0] REG_CYCLES_HI = 3'd6;

    // CTRL register bit positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

endpackage

// File: rtl/vortex_axil_regif.sv
// AXI4-Lite slave front end: independent AW/W capture, one outstanding
// write, single-beat reads. Register semantics live in the parent, which
// sees a write strobe plus offset/data and supplies read data and an
// error flag for the write being executed.
module vortex_axil_regif
    import vortex_axil_ctrl_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    output logic [1:0]                 s_axil_bresp,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       wr_en,
    output logic [2:0]                 wr_addr,
    output logic [31:0]                wr_data,
    input  logic                       wr_err,
    output logic                       rd_en,
    output logic [2:0]                 rd_addr,
    input  logic [31:0]                rd_data
);

    logic        out_en;
    logic        aw_held;
    logic        w_held;
    logic [2:0]  aw_off;
    logic [31:0] w_data_q;

    // Strobes are ignored (partial writes act as full) and only bits [4:2] decode
    logic unused_bits;
    assign unused_bits = ^{s_axil_wstrb,
                           s_axil_awaddr[AXIL_ADDR_WIDTH-1:5], s_axil_awaddr[1:0],
                           s_axil_araddr[AXIL_ADDR_WIDTH-1:5], s_axil_araddr[1:0]};

    assign s_axil_awready = out_en && !aw_held && !s_axil_bvalid;
    assign s_axil_wready  = out_en && !w_held && !s_axil_bvalid;
    assign s_axil_arready = out_en && !s_axil_rvalid;
    assign s_axil_rresp   = RESP_OKAY;

    assign wr_en   = aw_held && w_held;
    assign wr_addr = aw_off;
    assign wr_data = w_data_q;
    assign rd_en   = s_axil_arvalid && s_axil_arready;
    assign rd_addr = s_axil_araddr[4:2];

    // Latch AW and W independently, execute once both are held, then hold B until accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_en        <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_off        <= '0;
            w_data_q      <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            out_en <= 1'b1;
            if (s_axil_awvalid && s_axil_awready) begin
                aw_held <= 1'b1;
                aw_off  <= s_axil_awaddr[4:2];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_held   <= 1'b1;
                w_data_q <= s_axil_wdata;
            end
            if (wr_en) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    // Capture read data on the AR handshake and hold it until the R handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
        end else if (rd_en) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_data;
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/vortex_axil_ctrl.sv
// Host control block for Vortex devices: turns AXI4-Lite register writes
// into DCR write pulses, launches kernels on a device mask, tracks busy
// to completion and counts run cycles.
`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

module vortex_axil_ctrl
    import vortex_axil_ctrl_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int DCR_ADDR_WIDTH  = `VX_DCR_ADDR_WIDTH,
    parameter int DCR_DATA_WIDTH  = `VX_DCR_DATA_WIDTH,
    parameter int NUM_DEVICES     = 1,
    parameter int BUSY_TIMEOUT    = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    input  logic [31:0]                s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    output logic [1:0]                 s_axil_bresp,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [31:0]                s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic [NUM_DEVICES-1:0]     dcr_wr_valid,
    output logic [DCR_ADDR_WIDTH-1:0]  dcr_wr_addr,
    output logic [DCR_DATA_WIDTH-1:0]  dcr_wr_data,
    output logic [NUM_DEVICES-1:0]     dev_start,
    input  logic [NUM_DEVICES-1:0]     dev_busy,
    output logic                       irq
);

    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    logic                      wr_en;
    logic [2:0]                wr_addr;
    logic [31:0]               wr_data;
    logic                      wr_err;
    logic                      rd_en;
    logic [2:0]                rd_addr;
    logic [31:0]               rd_data;

    state_t                    state_q;
    state_t                    state_d;
    logic                      complete;
    logic [NUM_DEVICES-1:0]    dev_mask;
    logic [NUM_DEVICES-1:0]    run_mask;
    logic [DCR_ADDR_WIDTH-1:0] dcr_addr;
    logic [DCR_DATA_WIDTH-1:0] dcr_data;
    logic [63:0]               cycles;
    logic [31:0]               cyc_hi_snap;
    logic [TO_W-1:0]           to_cnt;
    logic                      done;

    logic                      wr_ctrl;
    logic                      start_req;
    logic                      clear_req;
    logic                      start_ok;
    logic                      dcr_wr_req;

    vortex_axil_regif #(
        .AXIL_ADDR_WIDTH(AXIL_ADDR_WIDTH)
    ) u_regif (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    assign wr_ctrl    = wr_en && (wr_addr == REG_CTRL);
    assign start_req  = wr_ctrl && wr_data[CTRL_START_BIT];
    assign clear_req  = wr_ctrl && wr_data[CTRL_CLEAR_BIT];
    assign start_ok   = start_req && (state_q == ST_IDLE) && (dev_mask != '0);
    assign dcr_wr_req = wr_en && (wr_addr == REG_DCR_DATA);
    assign wr_err     = (start_req && !start_ok) || (dcr_wr_req && (state_q != ST_IDLE));
    assign irq        = done;

    // Launch sequencing: next state, launch pulse and completion detection
    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        dev_start = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                dev_start = run_mask;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if ((dev_busy & run_mask) != '0) begin
                    state_d = ST_RUN;
                end else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((dev_busy & run_mask) == '0) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Busy-rise timeout, restarted on every launch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     to_cnt <= '0;
        else if (state_q == ST_LAUNCH)    to_cnt <= '0;
        else if (state_q == ST_WAIT_BUSY) to_cnt <= to_cnt + TO_W'(1);
    end

    // Run-cycle counter: cleared on start, counts whenever not idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 cycles <= '0;
        else if (start_ok)            cycles <= '0;
        else if (state_q != ST_IDLE)  cycles <= cycles + 64'd1;
    end

    // Sticky done: completion beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    done <= 1'b0;
        else if (complete)               done <= 1'b1;
        else if (start_ok || clear_req)  done <= 1'b0;
    end

    // Host-visible configuration, the per-run mask and the CYCLES_HI snapshot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dev_mask    <= '1;
            run_mask    <= '0;
            dcr_addr    <= '0;
            dcr_data    <= '0;
            cyc_hi_snap <= '0;
        end else begin
            if (wr_en && (wr_addr == REG_DEV_MASK)) dev_mask <= wr_data[NUM_DEVICES-1:0];
            if (wr_en && (wr_addr == REG_DCR_ADDR)) dcr_addr <= wr_data[DCR_ADDR_WIDTH-1:0];
            if (dcr_wr_req)                         dcr_data <= wr_data[DCR_DATA_WIDTH-1:0];
            if (start_ok)                           run_mask <= dev_mask;
            if (rd_en && (rd_addr == REG_CYCLES_LO)) cyc_hi_snap <= cycles[63:32];
        end
    end

    // One-cycle DCR write pulse, only issued while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcr_wr_valid <= '0;
            dcr_wr_addr  <= '0;
            dcr_wr_data  <= '0;
        end else begin
            dcr_wr_valid <= '0;
            if (dcr_wr_req && (state_q == ST_IDLE)) begin
                dcr_wr_valid <= dev_mask;
                dcr_wr_addr  <= dcr_addr;
                dcr_wr_data  <= wr_data[DCR_DATA_WIDTH-1:0];
            end
        end
    end

    // Read data mux; CTRL and unmapped offsets read as zero
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            REG_STATUS: begin
                rd_data[0]                 = (state_q != ST_IDLE);
                rd_data[1]                 = done;
                rd_data[8 +: NUM_DEVICES]  = dev_busy;
            end
            REG_DCR_ADDR:  rd_data = 32'(dcr_addr);
            REG_DCR_DATA:  rd_data = 32'(dcr_data);
            REG_DEV_MASK:  rd_data = 32'(dev_mask);
            REG_CYCLES_LO: rd_data = cycles[31:0];
            REG_CYCLES_HI: rd_data = cyc_hi_snap;
            default:       rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_vortex_axil_ctrl.sv
// Directed self-checking bench for vortex_axil_ctrl with two devices.
module tb_vortex_axil_ctrl;

    localparam int NDEV = 2;
    localparam int DAW  = 12;
    localparam int DDW  = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            s_axil_awvalid = 1'b0;
    logic            s_axil_awready;
    logic [7:0]      s_axil_awaddr = '0;
    logic            s_axil_wvalid = 1'b0;
    logic            s_axil_wready;
    logic [31:0]     s_axil_wdata = '0;
    logic [3:0]      s_axil_wstrb = '0;
    logic            s_axil_bvalid;
    logic            s_axil_bready = 1'b0;
    logic [1:0]      s_axil_bresp;
    logic            s_axil_arvalid = 1'b0;
    logic            s_axil_arready;
    logic [7:0]      s_axil_araddr = '0;
    logic            s_axil_rvalid;
    logic            s_axil_rready = 1'b0;
    logic [31:0]     s_axil_rdata;
    logic [1:0]      s_axil_rresp;
    logic [NDEV-1:0] dcr_wr_valid;
    logic [DAW-1:0]  dcr_wr_addr;
    logic [DDW-1:0]  dcr_wr_data;
    logic [NDEV-1:0] dev_start;
    logic [NDEV-1:0] dev_busy = '0;
    logic            irq;

    int checks = 0;
    int failures = 0;

    int              dcr_pulses = 0;
    logic [NDEV-1:0] last_dcr_valid = '0;
    logic [DAW-1:0]  last_dcr_addr = '0;
    logic [DDW-1:0]  last_dcr_data = '0;
    int              start_pulses = 0;
    logic [NDEV-1:0] last_start = '0;
    int              drv_n;

    vortex_axil_ctrl #(
        .AXIL_ADDR_WIDTH(8),
        .DCR_ADDR_WIDTH (DAW),
        .DCR_DATA_WIDTH (DDW),
        .NUM_DEVICES    (NDEV),
        .BUSY_TIMEOUT   (64)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .dcr_wr_valid   (dcr_wr_valid),
        .dcr_wr_addr    (dcr_wr_addr),
        .dcr_wr_data    (dcr_wr_data),
        .dev_start      (dev_start),
        .dev_busy       (dev_busy),
        .irq            (irq)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count DCR and launch pulses and remember the last of each
    always @(negedge clk) begin
        if (dcr_wr_valid != '0) begin
            dcr_pulses     <= dcr_pulses + 1;
            last_dcr_valid <= dcr_wr_valid;
            last_dcr_addr  <= dcr_wr_addr;
            last_dcr_data  <= dcr_wr_data;
        end
        if (dev_start != '0) begin
            start_pulses <= start_pulses + 1;
            last_start   <= dev_start;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Write with W leading AW by w_lead cycles and bready held off for b_delay cycles
    task automatic axilWriteSkew(input int w_lead, input int b_delay, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 output logic [1:0] resp, output int hold_cnt);
        int k;
        int n;
        logic aw_hs;
        logic w_hs;
        logic seen;
        resp = 2'b11;
        hold_cnt = 0;
        s_axil_awaddr  = addr;
        s_axil_wdata   = data;
        s_axil_wstrb   = strb;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b1;
        s_axil_bready  = 1'b0;
        k = 0;
        while ((k <= w_lead || s_axil_awvalid || s_axil_wvalid) && k < 60) begin
            if (k == w_lead) s_axil_awvalid = 1'b1;
            @(negedge clk);
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            @(posedge clk);
            #1;
            if (aw_hs) s_axil_awvalid = 1'b0;
            if (w_hs)  s_axil_wvalid  = 1'b0;
            k++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            seen = s_axil_bvalid;
            n++;
        end
        if (seen) begin
            for (int i = 0; i < b_delay; i++) begin
                if (s_axil_bvalid) hold_cnt++;
                @(negedge clk);
            end
            resp = s_axil_bresp;
            s_axil_bready = 1'b1;
            @(posedge clk);
            #1;
            s_axil_bready = 1'b0;
        end
    endtask

    task automatic axilWrite(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int hold;
        axilWriteSkew(0, 0, addr, data, 4'hf, resp, hold);
    endtask

    task automatic axilRead(input logic [7:0] addr, output logic [31:0] data);
        int n;
        logic hs;
        logic seen;
        data = 'x;
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        s_axil_rready  = 1'b0;
        n = 0;
        while (s_axil_arvalid && n < 60) begin
            @(negedge clk);
            hs = s_axil_arvalid && s_axil_arready;
            @(posedge clk);
            #1;
            if (hs) s_axil_arvalid = 1'b0;
            n++;
        end
        s_axil_arvalid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            seen = s_axil_rvalid;
            n++;
        end
        if (seen) begin
            data = s_axil_rdata;
            s_axil_rready = 1'b1;
            @(posedge clk);
            #1;
            s_axil_rready = 1'b0;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctl"}, {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
                                    s_axil_arready, s_axil_rvalid, s_axil_rresp, irq,
                                    dev_start, dcr_wr_valid}, 64'h0);
        checkOutput({tag, "_rdata"}, s_axil_rdata, 64'h0);
        checkOutput({tag, "_dcr_addr"}, dcr_wr_addr, 64'h0);
        checkOutput({tag, "_dcr_data"}, dcr_wr_data, 64'h0);
    endtask

    // Directed test sequence
    initial begin
        logic [1:0]  resp;
        logic [31:0] rdv;
        int          hold;
        int          n;
        int          dcr0;
        int          st0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        axilRead(8'h10, rdv);  checkOutput("rst_dev_mask", rdv, 64'h3);
        axilRead(8'h04, rdv);  checkOutput("rst_status", rdv, 64'h0);
        axilRead(8'h08, rdv);  checkOutput("rst_dcr_addr", rdv, 64'h0);
        axilRead(8'h14, rdv);  checkOutput("rst_cycles_lo", rdv, 64'h0);

        axilRead(8'h1c, rdv);  checkOutput("unmapped_rd", rdv, 64'h0);
        axilWrite(8'h1c, 32'hffff, resp);  checkOutput("unmapped_wr_resp", resp, 64'h0);
        axilRead(8'h00, rdv);  checkOutput("ctrl_rd", rdv, 64'h0);

        // DCR write with default mask
        dcr0 = dcr_pulses;
        axilWrite(8'h08, 32'h001, resp);       checkOutput("dcr_addr_resp", resp, 64'h0);
        axilWrite(8'h0c, 32'h8000_0000, resp); checkOutput("dcr_data_resp", resp, 64'h0);
        @(negedge clk);
        checkOutput("dcr_pulse_cnt", dcr_pulses - dcr0, 64'd1);
        checkOutput("dcr_valid", last_dcr_valid, 64'h3);
        checkOutput("dcr_addr", last_dcr_addr, 64'h001);
        checkOutput("dcr_data", last_dcr_data, 64'h8000_0000);
        axilRead(8'h0c, rdv);  checkOutput("dcr_data_rb", rdv, 64'h8000_0000);

        // W three cycles ahead of AW, partial strobe, late bready
        dcr0 = dcr_pulses;
        axilWriteSkew(3, 5, 8'h0c, 32'h1234_5678, 4'h3, resp, hold);
        checkOutput("wlead_resp", resp, 64'h0);
        checkOutput("wlead_bhold", hold, 64'd5);
        @(negedge clk);
        checkOutput("wlead_bvalid_drop", s_axil_bvalid, 64'h0);
        checkOutput("wlead_pulses", dcr_pulses - dcr0, 64'd1);
        checkOutput("wlead_data", last_dcr_data, 64'h1234_5678);

        // AW and W together, late bready
        dcr0 = dcr_pulses;
        axilWriteSkew(0, 5, 8'h0c, 32'hcafe_f00d, 4'hf, resp, hold);
        checkOutput("simul_resp", resp, 64'h0);
        checkOutput("simul_bhold", hold, 64'd5);
        @(negedge clk);
        checkOutput("simul_bvalid_drop", s_axil_bvalid, 64'h0);
        checkOutput("simul_pulses", dcr_pulses - dcr0, 64'd1);
        checkOutput("simul_data", last_dcr_data, 64'hcafe_f00d);

        // Start with an empty mask is refused
        st0 = start_pulses;
        axilWrite(8'h10, 32'h0, resp);  checkOutput("mask0_wr_resp", resp, 64'h0);
        axilRead(8'h10, rdv);           checkOutput("mask0_rb", rdv, 64'h0);
        axilWrite(8'h00, 32'h1, resp);  checkOutput("mask0_start_resp", resp, 64'h2);
        axilRead(8'h04, rdv);           checkOutput("mask0_status", rdv, 64'h0);
        checkOutput("mask0_no_start", start_pulses - st0, 64'd0);

        // Full run on device 0; busy rises 2 cycles after launch for 100 cycles
        axilWrite(8'h10, 32'hffff_fffd, resp);  checkOutput("mask1_wr_resp", resp, 64'h0);
        axilRead(8'h10, rdv);                   checkOutput("mask1_rb", rdv, 64'h1);
        st0 = start_pulses;
        dcr0 = dcr_pulses;
        fork
            begin
                drv_n = 0;
                while (drv_n < 50) begin
                    @(negedge clk);
                    if (dev_start[0]) break;
                    drv_n++;
                end
                if (drv_n < 50) begin
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    dev_busy[0] = 1'b1;
                    repeat (100) @(posedge clk);
                    #1;
                    dev_busy[0] = 1'b0;
                end
            end
        join_none
        axilWrite(8'h00, 32'h1, resp);   checkOutput("run_start_resp", resp, 64'h0);
        axilRead(8'h04, rdv);            checkOutput("run_status_running", rdv[0], 64'h1);
        axilWrite(8'h00, 32'h1, resp);   checkOutput("run_restart_resp", resp, 64'h2);
        axilWrite(8'h0c, 32'h55, resp);  checkOutput("run_dcr_resp", resp, 64'h2);
        axilWrite(8'h10, 32'h3, resp);   checkOutput("run_mask_resp", resp, 64'h0);
        dev_busy[1] = 1'b1;
        n = 0;
        while (!irq && n < 400) begin
            @(negedge clk);
            n++;
        end
        dev_busy[1] = 1'b0;
        @(negedge clk);
        checkOutput("run_irq", irq, 64'h1);
        checkOutput("run_start_cnt", start_pulses - st0, 64'd1);
        checkOutput("run_start_mask", last_start, 64'h1);
        checkOutput("run_no_dcr", dcr_pulses - dcr0, 64'd0);
        axilRead(8'h04, rdv);  checkOutput("run_status_done", rdv, 64'h2);
        axilRead(8'h14, rdv);  checkOutput("run_cycles_lo", rdv, 64'd103);
        axilRead(8'h18, rdv);  checkOutput("run_cycles_hi", rdv, 64'd0);
        axilRead(8'h0c, rdv);  checkOutput("run_dcr_data_rb", rdv, 64'h55);
        axilRead(8'h14, rdv);  checkOutput("run_cycles_frozen", rdv, 64'd103);

        // Clear done
        axilWrite(8'h00, 32'h2, resp);  checkOutput("clr_resp", resp, 64'h0);
        @(negedge clk);
        checkOutput("clr_irq", irq, 64'h0);
        axilRead(8'h04, rdv);  checkOutput("clr_status", rdv, 64'h0);

        // Timeout with no busy on either device
        axilWrite(8'h00, 32'h1, resp);  checkOutput("to_start_resp", resp, 64'h0);
        n = 0;
        while (!irq && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_irq", irq, 64'h1);
        checkOutput("to_start_mask", last_start, 64'h3);
        axilRead(8'h14, rdv);  checkOutput("to_cycles_lo", rdv, 64'd65);
        axilRead(8'h04, rdv);  checkOutput("to_status", rdv, 64'h2);

        // Reset in the middle of a run
        axilWrite(8'h00, 32'h1, resp);  checkOutput("mid_start_resp", resp, 64'h0);
        dev_busy = 2'b10;
        repeat (5) @(negedge clk);
        axilRead(8'h04, rdv);  checkOutput("mid_status", rdv, 64'h201);
        @(negedge clk);
        reset_n = 1'b0;
        st0 = start_pulses;
        dcr0 = dcr_pulses;
        @(negedge clk);
        checkResetOutputs("midrst");
        dev_busy = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_start", start_pulses - st0, 64'd0);
        checkOutput("midrst_no_dcr", dcr_pulses - dcr0, 64'd0);
        axilRead(8'h04, rdv);  checkOutput("midrst_status", rdv, 64'h0);
        axilRead(8'h10, rdv);  checkOutput("midrst_dev_mask", rdv, 64'h3);
        axilRead(8'h14, rdv);  checkOutput("midrst_cycles", rdv, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
